// File: rtl/gbar_req_arbiter_if.sv
// Request/response bundle between the cores, the global-barrier request arbiter and the barrier unit.
// master = arbiter view, slave = environment (cores + barrier unit) view.
interface gbar_req_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int BAR_ID_W  = 4
);
    localparam int NC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0]          core_req_valid;
    logic [NUM_CORES*BAR_ID_W-1:0] core_req_id;
    logic [NUM_CORES*NC_W-1:0]     core_req_size_m1;
    logic [NUM_CORES-1:0]          core_req_ready;
    logic                          gbar_req_valid;
    logic [BAR_ID_W-1:0]           gbar_req_id;
    logic [NC_W-1:0]               gbar_req_size_m1;
    logic [NC_W-1:0]               gbar_req_core_id;
    logic                          gbar_req_ready;
    logic                          gbar_rsp_valid;
    logic [BAR_ID_W-1:0]           gbar_rsp_id;
    logic                          core_rsp_valid;
    logic [BAR_ID_W-1:0]           core_rsp_id;

    modport master (
        input  core_req_valid, core_req_id, core_req_size_m1,
        input  gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
        output core_req_ready, gbar_req_valid, gbar_req_id, gbar_req_size_m1,
        output gbar_req_core_id, core_rsp_valid, core_rsp_id
    );

    modport slave (
        output core_req_valid, core_req_id, core_req_size_m1,
        output gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
        input  core_req_ready, gbar_req_valid, gbar_req_id, gbar_req_size_m1,
        input  gbar_req_core_id, core_rsp_valid, core_rsp_id
    );
endinterface

// File: rtl/gbar_req_arbiter.sv
// Round-robin merge of per-core global-barrier requests into one registered request channel,
// plus registered release broadcast. Optional perf counters under GBAR_ARB_PERF_EN.
module gbar_req_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int BAR_ID_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    gbar_req_arbiter_if.master   bus,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_release_cnt
);
    localparam int NC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0][BAR_ID_W-1:0] req_id_a;
    logic [NUM_CORES-1:0][NC_W-1:0]     req_sz_a;
    logic [NUM_CORES-1:0]               hi_req, pick_src, grant;
    logic [NC_W-1:0][NUM_CORES-1:0]     enc_mask;
    logic [NC_W-1:0]                    grant_idx, rr_ptr, rr_next;
    logic                               load, any_req, any_hi;

    logic                out_valid;
    logic [BAR_ID_W-1:0] out_id;
    logic [NC_W-1:0]     out_size_m1, out_core;
    logic                rsp_valid_q;
    logic [BAR_ID_W-1:0] rsp_id_q;

    assign req_id_a = bus.core_req_id;
    assign req_sz_a = bus.core_req_size_m1;

    assign load = !out_valid || bus.gbar_req_ready;

    // Requests at or above rr_ptr take priority; fall back to the full set to wrap around.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_hi
        assign hi_req[i] = bus.core_req_valid[i] && (NC_W'(i) >= rr_ptr);
    end

    assign any_req  = |bus.core_req_valid;
    assign any_hi   = |hi_req;
    assign pick_src = any_hi ? hi_req : bus.core_req_valid;
    assign grant    = pick_src & (-pick_src);

    for (genvar b = 0; b < NC_W; b++) begin : g_enc
        for (genvar i = 0; i < NUM_CORES; i++) begin : g_bit
            assign enc_mask[b][i] = grant[i] && (((i >> b) & 1) == 1);
        end
        assign grant_idx[b] = |enc_mask[b];
    end

    assign rr_next = (grant_idx == NC_W'(NUM_CORES - 1)) ? '0 : grant_idx + NC_W'(1);

    assign bus.core_req_ready = load ? grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_id      <= '0;
            out_size_m1 <= '0;
            out_core    <= '0;
            rr_ptr      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            if (load) begin
                out_valid <= any_req;
                if (any_req) begin
                    out_id      <= req_id_a[grant_idx];
                    out_size_m1 <= req_sz_a[grant_idx];
                    out_core    <= grant_idx;
                    rr_ptr      <= rr_next;
                end
            end
            rsp_valid_q <= bus.gbar_rsp_valid;
            if (bus.gbar_rsp_valid) rsp_id_q <= bus.gbar_rsp_id;
        end
    end

    assign bus.gbar_req_valid   = out_valid;
    assign bus.gbar_req_id      = out_id;
    assign bus.gbar_req_size_m1 = out_size_m1;
    assign bus.gbar_req_core_id = out_core;
    assign bus.core_rsp_valid   = rsp_valid_q;
    assign bus.core_rsp_id      = rsp_id_q;

`ifdef GBAR_ARB_PERF_EN
    logic [31:0] stall_q, rel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            rel_q   <= '0;
        end else begin
            if (out_valid && !bus.gbar_req_ready) stall_q <= stall_q + 32'd1;
            if (bus.gbar_rsp_valid)                rel_q   <= rel_q + 32'd1;
        end
    end

    assign perf_stall_cnt   = stall_q;
    assign perf_release_cnt = rel_q;
`else
    assign perf_stall_cnt   = '0;
    assign perf_release_cnt = '0;
`endif
endmodule

// File: tb/tb_gbar_req_arbiter.sv
// Bench for gbar_req_arbiter: directed vector table, hand-written stall/reset/perf sequences,
// and random traffic against a queue-level reference model.
module tb_gbar_req_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] perf_stall_cnt, perf_release_cnt;

    always #5 clk = ~clk;

    gbar_req_arbiter_if #(.NUM_CORES(N), .BAR_ID_W(4)) bif();

    gbar_req_arbiter #(.NUM_CORES(N), .BAR_ID_W(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bif),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_release_cnt (perf_release_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] id;
        logic [7:0]  sz;
        logic        gr;
        logic        rv;
        logic [3:0]  rid;
        logic [3:0]  e_rdy;
        logic        e_gv;
        logic        e_full;
        logic [3:0]  e_gid;
        logic [1:0]  e_gsz;
        logic [1:0]  e_gcore;
        logic        e_rv;
        logic [3:0]  e_rid;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [15:0] id, input logic [7:0] sz,
                         input logic gr, input logic rv, input logic [3:0] rid);
        @(negedge clk);
        bif.core_req_valid   = v;
        bif.core_req_id      = id;
        bif.core_req_size_m1 = sz;
        bif.gbar_req_ready   = gr;
        bif.gbar_rsp_valid   = rv;
        bif.gbar_rsp_id      = rid;
        #1;
    endtask

    task automatic chk_req(input string tag, input logic [3:0] e_rdy, input logic e_gv,
                           input logic full, input logic [3:0] gid, input logic [1:0] gsz,
                           input logic [1:0] gcore);
        chk({tag, ".ready"}, 32'(bif.core_req_ready), 32'(e_rdy));
        chk({tag, ".gvalid"}, 32'(bif.gbar_req_valid), 32'(e_gv));
        if (e_gv || full) begin
            chk({tag, ".gid"}, 32'(bif.gbar_req_id), 32'(gid));
            chk({tag, ".gsize"}, 32'(bif.gbar_req_size_m1), 32'(gsz));
            chk({tag, ".gcore"}, 32'(bif.gbar_req_core_id), 32'(gcore));
        end
    endtask

    task automatic chk_rsp(input string tag, input logic e_rv, input logic [3:0] e_rid);
        chk({tag, ".rsp_valid"}, 32'(bif.core_rsp_valid), 32'(e_rv));
        chk({tag, ".rsp_id"}, 32'(bif.core_rsp_id), 32'(e_rid));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bif.core_req_valid = '0;
        bif.gbar_rsp_valid = 1'b0;
        bif.gbar_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // reference model state
    int          m_ptr;
    bit          m_v;
    logic [3:0]  m_id;
    logic [1:0]  m_sz, m_core;
    bit          m_rv;
    logic [3:0]  m_rid;
    int unsigned m_stall, m_rel;
    bit          pend[N];
    logic [3:0]  pid[N];
    logic [1:0]  psz[N];

    initial begin
        // v, id, sz, gr, rv, rid | e_rdy, e_gv, e_full, e_gid, e_gsz, e_gcore, e_rv, e_rid
        tbl[0]  = '{4'h0, 16'h0000, 8'h00, 1, 0, 4'd0, 4'h0, 0, 1, 4'd0,  2'd0, 2'd0, 0, 4'd0};
        tbl[1]  = '{4'hF, 16'hBA98, 8'hE4, 1, 0, 4'd0, 4'h1, 0, 1, 4'd0,  2'd0, 2'd0, 0, 4'd0};
        tbl[2]  = '{4'hF, 16'hBA98, 8'hE4, 1, 0, 4'd0, 4'h2, 1, 1, 4'd8,  2'd0, 2'd0, 0, 4'd0};
        tbl[3]  = '{4'hF, 16'hBA98, 8'hE4, 1, 0, 4'd0, 4'h4, 1, 1, 4'd9,  2'd1, 2'd1, 0, 4'd0};
        tbl[4]  = '{4'hF, 16'hBA98, 8'hE4, 1, 0, 4'd0, 4'h8, 1, 1, 4'd10, 2'd2, 2'd2, 0, 4'd0};
        tbl[5]  = '{4'hF, 16'hBA98, 8'hE4, 1, 0, 4'd0, 4'h1, 1, 1, 4'd11, 2'd3, 2'd3, 0, 4'd0};
        tbl[6]  = '{4'h0, 16'h0000, 8'h00, 1, 0, 4'd0, 4'h0, 1, 1, 4'd8,  2'd0, 2'd0, 0, 4'd0};
        tbl[7]  = '{4'h4, 16'h0500, 8'h30, 1, 0, 4'd0, 4'h4, 0, 0, 4'd0,  2'd0, 2'd0, 0, 4'd0};
        tbl[8]  = '{4'h0, 16'h0000, 8'h00, 1, 0, 4'd0, 4'h0, 1, 1, 4'd5,  2'd3, 2'd2, 0, 4'd0};
        tbl[9]  = '{4'h0, 16'h0000, 8'h00, 1, 1, 4'd7, 4'h0, 0, 0, 4'd0,  2'd0, 2'd0, 0, 4'd0};
        tbl[10] = '{4'h0, 16'h0000, 8'h00, 1, 1, 4'd2, 4'h0, 0, 0, 4'd0,  2'd0, 2'd0, 1, 4'd7};
        tbl[11] = '{4'h0, 16'h0000, 8'h00, 1, 0, 4'd9, 4'h0, 0, 0, 4'd0,  2'd0, 2'd0, 1, 4'd2};
        tbl[12] = '{4'h0, 16'h0000, 8'h00, 1, 0, 4'd0, 4'h0, 0, 0, 4'd0,  2'd0, 2'd0, 0, 4'd2};
        tbl[13] = '{4'h2, 16'h0060, 8'h04, 1, 1, 4'd7, 4'h2, 0, 0, 4'd0,  2'd0, 2'd0, 0, 4'd2};
        tbl[14] = '{4'h0, 16'h0000, 8'h00, 1, 0, 4'd0, 4'h0, 1, 1, 4'd6,  2'd1, 2'd1, 1, 4'd7};
        tbl[15] = '{4'h0, 16'h0000, 8'h00, 1, 0, 4'd0, 4'h0, 0, 0, 4'd0,  2'd0, 2'd0, 0, 4'd7};

        bif.core_req_valid   = '0;
        bif.core_req_id      = '0;
        bif.core_req_size_m1 = '0;
        bif.gbar_req_ready   = 1'b1;
        bif.gbar_rsp_valid   = 1'b0;
        bif.gbar_rsp_id      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].id, tbl[i].sz, tbl[i].gr, tbl[i].rv, tbl[i].rid);
            chk_req($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_gv, tbl[i].e_full,
                    tbl[i].e_gid, tbl[i].e_gsz, tbl[i].e_gcore);
            chk_rsp($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_rid);
        end

        // backpressure: pointer sits at 2, cores 1 and 3 requesting
        drive(4'b1010, 16'hC030, 8'h48, 0, 0, 4'd0);
        chk_req("bp_fill", 4'b1000, 0, 0, 4'd0, 2'd0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            drive(4'b1010, 16'hD030, 8'h08, 0, 0, 4'd0);
            chk_req("bp_hold", 4'b0000, 1, 1, 4'd12, 2'd1, 2'd3);
        end
        drive(4'b1010, 16'hD030, 8'h08, 1, 0, 4'd0);
        chk_req("bp_release", 4'b0010, 1, 1, 4'd12, 2'd1, 2'd3);
        drive(4'b1000, 16'hD000, 8'h00, 1, 0, 4'd0);
        chk_req("bp_next", 4'b1000, 1, 1, 4'd3, 2'd2, 2'd1);
        drive(4'b0000, 16'h0000, 8'h00, 1, 0, 4'd0);
        chk_req("bp_last", 4'b0000, 1, 1, 4'd13, 2'd0, 2'd3);

        // asynchronous reset while the output stage is full and stalled
        drive(4'b0001, 16'h0004, 8'h02, 0, 0, 4'd0);
        chk_req("rm_fill", 4'b0001, 0, 0, 4'd0, 2'd0, 2'd0);
        drive(4'b0000, 16'h0000, 8'h00, 0, 1, 4'd5);
        chk_req("rm_stall", 4'b0000, 1, 1, 4'd4, 2'd2, 2'd0);
        drive(4'b0000, 16'h0000, 8'h00, 0, 0, 4'd0);
        chk_rsp("rm_pre", 1, 4'd5);
        #1 reset_n = 1'b0;
        #1;
        chk("rm_async.gvalid", 32'(bif.gbar_req_valid), 32'd0);
        chk("rm_async.rsp_valid", 32'(bif.core_rsp_valid), 32'd0);
        chk("rm_async.rsp_id", 32'(bif.core_rsp_id), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(4'hF, 16'hBA98, 8'hE4, 1, 0, 4'd0);
        chk_req("rm_restart", 4'b0001, 0, 0, 4'd0, 2'd0, 2'd0);
        drive(4'h0, 16'h0000, 8'h00, 1, 0, 4'd0);

        // perf: 5 stall cycles, 2 releases
        do_reset();
        drive(4'b0001, 16'h0001, 8'h00, 0, 0, 4'd0);
        for (int k = 0; k < 5; k++)
            drive(4'b0000, 16'h0000, 8'h00, 0, (k == 1 || k == 3), 4'd1);
        drive(4'b0000, 16'h0000, 8'h00, 1, 0, 4'd0);
        drive(4'b0000, 16'h0000, 8'h00, 1, 0, 4'd0);
`ifdef GBAR_ARB_PERF_EN
        chk("perf_stall", perf_stall_cnt, 32'd5);
        chk("perf_release", perf_release_cnt, 32'd2);
`else
        chk("perf_stall", perf_stall_cnt, 32'd0);
        chk("perf_release", perf_release_cnt, 32'd0);
`endif

        // random traffic against the reference model
        do_reset();
        m_ptr = 0; m_v = 0; m_id = '0; m_sz = '0; m_core = '0;
        m_rv = 0; m_rid = '0; m_stall = 0; m_rel = 0;
        for (int c = 0; c < N; c++) pend[c] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [3:0]  v, rid, e_rdy;
            logic [15:0] idb;
            logic [7:0]  szb;
            logic        gr, rv, load;
            int          g;
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    pend[c] = 1;
                    pid[c]  = 4'($urandom_range(0, 15));
                    psz[c]  = 2'($urandom_range(0, 3));
                end
                v[c]            = pend[c];
                idb[c*4 +: 4]   = pid[c];
                szb[c*2 +: 2]   = psz[c];
            end
            gr  = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 2) == 0);
            rid = 4'($urandom_range(0, 15));
            drive(v, idb, szb, gr, rv, rid);

            load = !m_v || gr;
            g = -1;
            if (load)
                for (int k = 0; k < N; k++)
                    if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            e_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
            chk_req("rnd", e_rdy, m_v, 0, m_id, m_sz, m_core);
            chk_rsp("rnd", m_rv, m_rid);

            if (m_v && !gr) m_stall++;
            if (rv) m_rel++;
            if (load) begin
                if (g >= 0) begin
                    m_v = 1; m_id = pid[g]; m_sz = psz[g]; m_core = 2'(g);
                    m_ptr = (g + 1) % N;
                    pend[g] = 0;
                end else begin
                    m_v = 0;
                end
            end
            m_rv = rv;
            if (rv) m_rid = rid;
        end
        drive(4'b0000, 16'h0000, 8'h00, 1, 0, 4'd0);
`ifdef GBAR_ARB_PERF_EN
        chk("rnd_perf_stall", perf_stall_cnt, m_stall);
        chk("rnd_perf_release", perf_release_cnt, m_rel);
`else
        chk("rnd_perf_stall", perf_stall_cnt, 32'd0);
        chk("rnd_perf_release", perf_release_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
